// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-bit multiply/divide sequencer that owns the hi/lo register write port.
// One shift-add or restoring-divide step per cycle, then a single-cycle hi/lo commit.
module hilo_muldiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] reg_rs_value,
  input  logic [31:0] reg_rt_value,
  input  logic        hilo_read,
  output logic        busy,
  output logic        stall,
  output logic        control_hilo_write,
  output logic [31:0] reg_hi_w,
  output logic [31:0] reg_lo_w,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  state_t      state, state_next;
  logic [5:0]  count;

  logic        is_div, neg_res, neg_rem;
  logic [31:0] rs_raw;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;   // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [31:0] divisor;
  logic [31:0] rem;

  logic [63:0] acc_step;
  logic [32:0] shifted, trial;
  logic [31:0] rem_step, q_step;
  logic [63:0] mul_result;
  logic [31:0] quot_result, rem_result;
  logic        accept, last_step;

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  assign busy      = (state != IDLE);
  assign stall     = busy & (start | hilo_read);
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (count == 6'd31);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == 6'd31) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of either datapath; the final fix-ups see the 32nd step directly.
  always_comb begin
    acc_step = acc + (mplier[0] ? mcand : 64'd0);
    shifted  = {rem, mplier[31]};
    trial    = shifted - {1'b0, divisor};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      q_step   = {mplier[30:0], 1'b1};
    end else begin
      rem_step = shifted[31:0];
      q_step   = {mplier[30:0], 1'b0};
    end
    mul_result  = cond_neg64(acc_step, neg_res);
    quot_result = cond_neg32(q_step, neg_res);
    rem_result  = cond_neg32(rem_step, neg_rem);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state              <= IDLE;
      count              <= 6'd0;
      control_hilo_write <= 1'b0;
      div_by_zero        <= 1'b0;
      reg_hi_w           <= 32'd0;
      reg_lo_w           <= 32'd0;
    end else begin
      state              <= state_next;
      control_hilo_write <= 1'b0;
      div_by_zero        <= 1'b0;
      if (accept) count <= 6'd0;
      else if (state == RUN) count <= count + 6'd1;
      if (last_step) begin
        control_hilo_write <= 1'b1;
        if (!is_div) begin
          reg_hi_w <= mul_result[63:32];
          reg_lo_w <= mul_result[31:0];
        end else if (divisor == 32'd0) begin
          reg_hi_w    <= rs_raw;
          reg_lo_w    <= 32'hFFFF_FFFF;
          div_by_zero <= 1'b1;
        end else begin
          reg_hi_w <= rem_result;
          reg_lo_w <= quot_result;
        end
      end
    end
  end

  // Datapath registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      is_div  <= op[1];
      neg_res <= ~op[0] & (reg_rs_value[31] ^ reg_rt_value[31]);
      neg_rem <= ~op[0] & reg_rs_value[31];
      rs_raw  <= reg_rs_value;
      acc     <= 64'd0;
      rem     <= 32'd0;
      mcand   <= {32'd0, magnitude(reg_rs_value, ~op[0])};
      mplier  <= op[1] ? magnitude(reg_rs_value, ~op[0]) : magnitude(reg_rt_value, ~op[0]);
      divisor <= magnitude(reg_rt_value, ~op[0]);
    end else if (state == RUN) begin
      if (!is_div) begin
        acc    <= acc_step;
        mcand  <= {mcand[62:0], 1'b0};
        mplier <= {1'b0, mplier[31:1]};
      end else begin
        rem    <= rem_step;
        mplier <= q_step;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit: latency, results, stall and reset abort.
module tb_hilo_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] reg_rs_value, reg_rt_value;
  logic        hilo_read;
  logic        busy, stall, control_hilo_write, div_by_zero;
  logic [31:0] reg_hi_w, reg_lo_w;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  hilo_muldiv_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .reg_rs_value(reg_rs_value), .reg_rt_value(reg_rt_value), .hilo_read(hilo_read),
    .busy(busy), .stall(stall), .control_hilo_write(control_hilo_write),
    .reg_hi_w(reg_hi_w), .reg_lo_w(reg_lo_w), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Issues one operation and follows it for 33 edges after the accepting edge.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int busy_cycles = 0, writes = 0, write_edge = -1, dz_pulses = 0, dz_at_write = 0;
    logic [31:0] hi_at_write = 32'd0, lo_at_write = 32'd0;
    @(negedge clock);
    start = 1'b1; op = o; reg_rs_value = rs; reg_rt_value = rt;
    @(posedge clock); #1;
    start = 1'b0; reg_rs_value = 32'hDEAD_BEEF; reg_rt_value = 32'h0BAD_F00D;
    if (busy) busy_cycles++;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clock); #1;
      if (busy) busy_cycles++;
      if (div_by_zero) dz_pulses++;
      if (control_hilo_write) begin
        writes++;
        write_edge = i;
        hi_at_write = reg_hi_w;
        lo_at_write = reg_lo_w;
        dz_at_write = int'(div_by_zero);
      end
    end
    tests++; if (writes !== 1) begin fails++; $display("FAIL %s write_count got %0d want 1", name, writes); end
    tests++; if (write_edge !== 32) begin fails++; $display("FAIL %s write_edge got %0d want 32", name, write_edge); end
    tests++; if (busy_cycles !== 33) begin fails++; $display("FAIL %s busy_cycles got %0d want 33", name, busy_cycles); end
    tests++; if (hi_at_write !== exp_hi) begin fails++; $display("FAIL %s hi got %h want %h", name, hi_at_write, exp_hi); end
    tests++; if (lo_at_write !== exp_lo) begin fails++; $display("FAIL %s lo got %h want %h", name, lo_at_write, exp_lo); end
    tests++; if (dz_at_write !== int'(exp_dz)) begin fails++; $display("FAIL %s dz_at_write got %0d want %0d", name, dz_at_write, exp_dz); end
    tests++; if (dz_pulses !== int'(exp_dz)) begin fails++; $display("FAIL %s dz_pulses got %0d want %0d", name, dz_pulses, exp_dz); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; op = MULTU; reg_rs_value = 32'd9; reg_rt_value = 32'd9; hilo_read = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset stall got %b want 0", stall); end
    tests++; if ({control_hilo_write, div_by_zero} !== 2'b00) begin fails++; $display("FAIL reset write_dz got %b want 00", {control_hilo_write, div_by_zero}); end
    tests++; if ({reg_hi_w, reg_lo_w} !== 64'd0) begin fails++; $display("FAIL reset hilo got %h want 0", {reg_hi_w, reg_lo_w}); end
    @(negedge clock);
    start = 1'b0; hilo_read = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_multiply();
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    tests++; if ({reg_hi_w, reg_lo_w} !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL hold_idle got %h want fffffffe00000001", {reg_hi_w, reg_lo_w}); end
    run_op("mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_minxmin", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_divide();
    run_op("div_neg7by2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7by2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div_min_by_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_div_by_zero();
    run_op("div_by_zero", DIV, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_stall();
    int writes = 0, stall_bad = 0;
    @(negedge clock);
    start = 1'b1; op = MULTU; reg_rs_value = 32'd6; reg_rt_value = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clock);
      start = (i >= 5 && i <= 8); hilo_read = (i == 12);
      op = DIVU; reg_rs_value = 32'd100; reg_rt_value = 32'd3;
      #1;
      if (stall !== (start | hilo_read)) stall_bad++;
      @(posedge clock); #1;
      if (control_hilo_write) writes++;
    end
    start = 1'b0; hilo_read = 1'b0;
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL stall_midrun bad_cycles got %0d want 0", stall_bad); end
    tests++; if (writes !== 1) begin fails++; $display("FAIL stall_writes got %0d want 1", writes); end
    tests++; if ({reg_hi_w, reg_lo_w} !== 64'd42) begin fails++; $display("FAIL stall_result got %h want 42", {reg_hi_w, reg_lo_w}); end
    repeat (3) @(posedge clock);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stall_no_second_op busy got %b want 0", busy); end
    @(negedge clock);
    hilo_read = 1'b1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL idle_hilo_read stall got %b want 0", stall); end
    hilo_read = 1'b0;
  endtask

  task automatic test_reset_abort();
    int writes = 0;
    @(negedge clock);
    start = 1'b1; op = MULTU; reg_rs_value = 32'h0000_FFFF; reg_rt_value = 32'h0000_FFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if ({reg_hi_w, reg_lo_w} !== 64'd0) begin fails++; $display("FAIL abort_hilo got %h want 0", {reg_hi_w, reg_lo_w}); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (control_hilo_write) writes++;
    end
    tests++; if (writes !== 0) begin fails++; $display("FAIL abort_no_write got %0d want 0", writes); end
    run_op("multu_3x5_after_abort", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = MULT; hilo_read = 1'b0;
    reg_rs_value = 32'd0; reg_rt_value = 32'd0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_stall();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
